memwb_stage: RTL and testbench
==============================

Name: memwb_stage

Overview:
- Memory-access / write-back stage of miniCPU; sits directly upstream of the register file.
- Takes one executed instruction per accept from the execute stage.
- Performs the data-memory load/store handshake.
- Drives the regfile write port (dstM/valM, dstE/valE, active-low we_) for exactly one cycle per retired instruction.

Parameters:
- DATA_W, 16, data/address width (matches `DataBus).
- TIMEOUT, 15, max cycles waiting for mem_ack (used only with MEMWB_BUSERR_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute stage presents an instruction.
- ex_load  in  1  instruction is a load.
- ex_store  in  1  instruction is a store.
- ex_dstE  in  3  ALU result destination (0 = none).
- ex_dstM  in  3  load destination (0 = none).
- ex_valE  in  DATA_W  ALU result; also memory address for load/store.
- ex_valA  in  DATA_W  store data.
- ex_stall  out  1  stage busy; execute must hold its outputs.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  memory done; rdata valid the same cycle for loads.
- mem_rdata  in  DATA_W  load data.
- dstM  out  3  regfile M destination.
- dstE  out  3  regfile E destination.
- valM  out  DATA_W  regfile M data.
- valE  out  DATA_W  regfile E data.
- we_  out  1  regfile write enable, active-low.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_ low, asynchronous, any state, including mid-transaction):
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - we_=1; dstM=dstE=0; valM=valE=0; bus_err=0.
  - Any pending transaction is abandoned and never retires.
- States: IDLE, MEM_WAIT. ex_stall = (state==MEM_WAIT), purely combinational from state.
- Accept: ex_valid=1 in IDLE.
- Non-memory accept (ex_load=ex_store=0), next edge:
  - we_=0, dstE=ex_dstE, valE=ex_valE, dstM=0, valM=0.
  - Latency 1; back-to-back accepts every cycle allowed.
- Load or store accept, next edge:
  - state->MEM_WAIT; mem_req=1; mem_addr=ex_valE; mem_we=ex_store; mem_wdata=ex_valA (0 for loads).
  - dstE, dstM and valE are captured internally.
  - ex_load and ex_store both set: treat as a load; store ignored, mem_we=0.
- MEM_WAIT:
  - mem_req and address/data held stable until ack.
  - mem_ack is sampled only in MEM_WAIT; an ack in IDLE is ignored.
  - Ack edge:
    - mem_req=0, mem_we=0, state->IDLE, we_=0.
    - dstE/valE = captured values.
    - Load: dstM=captured dstM, valM=mem_rdata.
    - Store: dstM=0, valM=0.
  - ex_stall falls in the cycle after ack. Minimum load/store occupancy is 2 cycles (ack on the first request cycle).
- Write-port pulse:
  - we_ is low for exactly one cycle per retired instruction.
  - Every cycle without a retirement: we_=1, dstM=dstE=0, valM/valE hold their last values.
  - dst=0 with we_=0 is legal; the regfile ignores R0.
- ex_valid=0 in IDLE: no state change.
- Inputs while ex_stall=1: ignored.

Optional Feature:
- Macro: MEMWB_BUSERR_EN.
- With the macro defined:
  - Counter cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle without ack.
  - When the count reaches TIMEOUT without ack: abort. mem_req=0, state->IDLE, retire normally with valM=0 for loads, bus_err set.
  - bus_err stays 1 until reset.
  - An ack in the same cycle as expiry wins: normal retire, no error.
- Without the macro: MEM_WAIT waits indefinitely; bus_err tied 0; no counter logic.

Test Plan:
- Reset check: rst_ low mid-MEM_WAIT (mem_req=1) -> mem_req=0, we_=1, ex_stall=0 immediately; no retirement after release.
- ALU stream: accept ex_dstE=3/valE=0x1234, then dstE=5/valE=0x00FF on consecutive cycles -> we_ low 2 consecutive cycles with those values in order; ex_stall stays 0.
- Load with ack after 3 cycles: ex_load, ex_dstM=2, ex_valE=0x0040; mem_rdata=0xBEEF -> mem_addr=0x0040, mem_we=0, mem_req high 3 cycles; then one cycle we_=0, dstM=2, valM=0xBEEF; ex_stall deasserts the next cycle.
- Store with immediate ack: ex_store, valE=0x0010, valA=0xA5A5, dstE=0 -> mem_we=1, mem_wdata=0xA5A5 for 1 cycle; retire with dstM=0; stray mem_ack in IDLE -> no effect.
- Load+store both set, dstM=4 -> treated as load: mem_we=0, retire with dstM=4.
- MEMWB_BUSERR_EN, TIMEOUT=15, load with no ack -> abort after 15 wait cycles; we_ pulse with valM=0; bus_err=1 sticky until rst_.

Source files
------------

// File: rtl/memwb_stage.sv
// miniCPU memory-access / write-back stage: load/store handshake and one-cycle regfile write pulse.
// Optional MEMWB_BUSERR_EN adds a mem_ack timeout that aborts the access and sets sticky bus_err.
module memwb_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_dstE,
  input  logic [2:0]        ex_dstM,
  input  logic [DATA_W-1:0] ex_valE,
  input  logic [DATA_W-1:0] ex_valA,
  output logic              ex_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dstM,
  output logic [2:0]        dstE,
  output logic [DATA_W-1:0] valM,
  output logic [DATA_W-1:0] valE,
  output logic              we_,
  output logic              bus_err
);

  localparam int unsigned REG_W = 3;

  typedef enum logic {IDLE, MEM_WAIT} state_e;

  state_e              state, state_d;
  logic                mem_req_d, mem_we_d, we_d;
  logic [DATA_W-1:0]   mem_addr_d, mem_wdata_d, valM_d, valE_d;
  logic [REG_W-1:0]    dstM_d, dstE_d;
  logic                cap_load, cap_load_d;
  logic [REG_W-1:0]    cap_dstE, cap_dstE_d, cap_dstM, cap_dstM_d;
  logic [DATA_W-1:0]   cap_valE, cap_valE_d;
  logic                bus_err_d;

`ifdef MEMWB_BUSERR_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
`endif

  assign ex_stall = (state == MEM_WAIT);

  // Next-state and next-output logic; non-retiring cycles leave we_ high and dst at R0.
  always_comb begin
    state_d     = state;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    we_d        = 1'b1;
    dstM_d      = '0;
    dstE_d      = '0;
    valM_d      = valM;
    valE_d      = valE;
    cap_load_d  = cap_load;
    cap_dstE_d  = cap_dstE;
    cap_dstM_d  = cap_dstM;
    cap_valE_d  = cap_valE;
    bus_err_d   = bus_err;
`ifdef MEMWB_BUSERR_EN
    wait_cnt_d  = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (ex_load || ex_store) begin
            state_d     = MEM_WAIT;
            mem_req_d   = 1'b1;
            mem_addr_d  = ex_valE;
            mem_we_d    = ex_store && !ex_load;
            mem_wdata_d = ex_load ? '0 : ex_valA;
            cap_load_d  = ex_load;
            cap_dstE_d  = ex_dstE;
            cap_dstM_d  = ex_dstM;
            cap_valE_d  = ex_valE;
`ifdef MEMWB_BUSERR_EN
            wait_cnt_d  = '0;
`endif
          end else begin
            we_d   = 1'b0;
            dstE_d = ex_dstE;
            valE_d = ex_valE;
            valM_d = '0;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          we_d      = 1'b0;
          dstE_d    = cap_dstE;
          valE_d    = cap_valE;
          dstM_d    = cap_load ? cap_dstM : '0;
          valM_d    = cap_load ? mem_rdata : '0;
        end
`ifdef MEMWB_BUSERR_EN
        // Timeout abort still retires, but loads write zero.
        else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          we_d      = 1'b0;
          dstE_d    = cap_dstE;
          valE_d    = cap_valE;
          dstM_d    = cap_load ? cap_dstM : '0;
          valM_d    = '0;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_       <= 1'b1;
      dstM      <= '0;
      dstE      <= '0;
      valM      <= '0;
      valE      <= '0;
      cap_load  <= 1'b0;
      cap_dstE  <= '0;
      cap_dstM  <= '0;
      cap_valE  <= '0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      we_       <= we_d;
      dstM      <= dstM_d;
      dstE      <= dstE_d;
      valM      <= valM_d;
      valE      <= valE_d;
      cap_load  <= cap_load_d;
      cap_dstE  <= cap_dstE_d;
      cap_dstM  <= cap_dstM_d;
      cap_valE  <= cap_valE_d;
      bus_err   <= bus_err_d;
    end
  end

`ifdef MEMWB_BUSERR_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) wait_cnt <= '0;
    else       wait_cnt <= wait_cnt_d;
  end
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Bench for memwb_stage: directed vector table, reset/timeout sequences, and random traffic vs a queue model.
module tb_memwb_stage;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_;
  logic              ex_valid, ex_load, ex_store;
  logic [2:0]        ex_dstE, ex_dstM;
  logic [DATA_W-1:0] ex_valE, ex_valA;
  logic              ex_stall, mem_req, mem_we, mem_ack, we_, bus_err;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata, valM, valE;
  logic [2:0]        dstM, dstE;

  int checks = 0;
  int errors = 0;

  memwb_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_(rst_),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_dstE(ex_dstE), .ex_dstM(ex_dstM), .ex_valE(ex_valE), .ex_valA(ex_valA),
    .ex_stall(ex_stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dstM(dstM), .dstE(dstE), .valM(valM), .valE(valE), .we_(we_), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] de,
                       input logic [2:0] dm, input logic [15:0] ve, input logic [15:0] va,
                       input logic ack, input logic [15:0] rd);
    ex_valid = v; ex_load = ld; ex_store = st; ex_dstE = de; ex_dstM = dm;
    ex_valE = ve; ex_valA = va; mem_ack = ack; mem_rdata = rd;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0);
    tick();
    tick();
    rst_ = 1'b1;
  endtask

  task automatic chk_retire(string tag, logic [2:0] de, logic [2:0] dm, logic [15:0] ve, logic [15:0] vm);
    chk({tag, ".we_"},  32'(we_),  32'(1'b0));
    chk({tag, ".dstE"}, 32'(dstE), 32'(de));
    chk({tag, ".dstM"}, 32'(dstM), 32'(dm));
    chk({tag, ".valE"}, 32'(valE), 32'(ve));
    chk({tag, ".valM"}, 32'(valM), 32'(vm));
  endtask

  typedef struct {
    logic v, ld, st;
    logic [2:0] de, dm;
    logic [15:0] ve, va;
    logic ack;
    logic [15:0] rd;
    logic xwe;
    logic [2:0] xde, xdm;
    logic [15:0] xve, xvm;
    logic xreq, xmwe;
    logic [15:0] xaddr, xwd;
    logic xstall;
  } vec_t;

  typedef struct {
    logic ld;
    logic [2:0] de, dm;
    logic [15:0] ve;
  } pend_t;

  vec_t vec[12];

  initial begin
    // Directed table: one row per cycle, inputs then expected post-edge outputs.
    vec[0]  = '{1,0,0, 3'd3,3'd0, 16'h1234,16'h0, 0,16'h0,     0, 3'd3,3'd0, 16'h1234,16'h0000, 0,0, 16'h0,16'h0,    0};
    vec[1]  = '{1,0,0, 3'd5,3'd0, 16'h00FF,16'h0, 0,16'h0,     0, 3'd5,3'd0, 16'h00FF,16'h0000, 0,0, 16'h0,16'h0,    0};
    vec[2]  = '{0,0,0, 3'd0,3'd0, 16'h0,16'h0,    0,16'h0,     1, 3'd0,3'd0, 16'h00FF,16'h0000, 0,0, 16'h0,16'h0,    0};
    vec[3]  = '{1,1,0, 3'd0,3'd2, 16'h0040,16'h9, 0,16'h0,     1, 3'd0,3'd0, 16'h00FF,16'h0000, 1,0, 16'h0040,16'h0, 1};
    vec[4]  = '{1,0,0, 3'd7,3'd0, 16'h7777,16'h0, 0,16'h0,     1, 3'd0,3'd0, 16'h00FF,16'h0000, 1,0, 16'h0040,16'h0, 1};
    vec[5]  = '{1,0,1, 3'd6,3'd0, 16'h6666,16'h5, 0,16'h0,     1, 3'd0,3'd0, 16'h00FF,16'h0000, 1,0, 16'h0040,16'h0, 1};
    vec[6]  = '{0,0,0, 3'd0,3'd0, 16'h0,16'h0,    1,16'hBEEF,  0, 3'd0,3'd2, 16'h0040,16'hBEEF, 0,0, 16'h0,16'h0,    0};
    vec[7]  = '{1,0,1, 3'd0,3'd0, 16'h0010,16'hA5A5, 0,16'h0,  1, 3'd0,3'd0, 16'h0040,16'hBEEF, 1,1, 16'h0010,16'hA5A5, 1};
    vec[8]  = '{0,0,0, 3'd0,3'd0, 16'h0,16'h0,    1,16'h1111,  0, 3'd0,3'd0, 16'h0010,16'h0000, 0,0, 16'h0,16'h0,    0};
    vec[9]  = '{0,0,0, 3'd0,3'd0, 16'h0,16'h0,    1,16'h2222,  1, 3'd0,3'd0, 16'h0010,16'h0000, 0,0, 16'h0,16'h0,    0};
    vec[10] = '{1,1,1, 3'd1,3'd4, 16'h0022,16'h7777, 0,16'h0,  1, 3'd0,3'd0, 16'h0010,16'h0000, 1,0, 16'h0022,16'h0, 1};
    vec[11] = '{0,0,0, 3'd0,3'd0, 16'h0,16'h0,    1,16'h1357,  0, 3'd1,3'd4, 16'h0022,16'h1357, 0,0, 16'h0,16'h0,    0};

    do_reset();
    #1;
    chk("rst.mem_req",  32'(mem_req),  32'(1'b0));
    chk("rst.we_",      32'(we_),      32'(1'b1));
    chk("rst.dst",      32'({dstE, dstM}), 32'(6'd0));
    chk("rst.vals",     32'({valE, valM}), 32'h0);
    chk("rst.mem_addr", 32'(mem_addr), 32'h0);
    chk("rst.ex_stall", 32'(ex_stall), 32'(1'b0));
    chk("rst.bus_err",  32'(bus_err),  32'(1'b0));

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      drive(vec[i].v, vec[i].ld, vec[i].st, vec[i].de, vec[i].dm, vec[i].ve, vec[i].va, vec[i].ack, vec[i].rd);
      tick();
      chk($sformatf("vec%0d.we_", i),   32'(we_),  32'(vec[i].xwe));
      chk($sformatf("vec%0d.dstE", i),  32'(dstE), 32'(vec[i].xde));
      chk($sformatf("vec%0d.dstM", i),  32'(dstM), 32'(vec[i].xdm));
      chk($sformatf("vec%0d.valE", i),  32'(valE), 32'(vec[i].xve));
      chk($sformatf("vec%0d.valM", i),  32'(valM), 32'(vec[i].xvm));
      chk($sformatf("vec%0d.req", i),   32'(mem_req), 32'(vec[i].xreq));
      chk($sformatf("vec%0d.mem_we", i), 32'(mem_we), 32'(vec[i].xmwe));
      chk($sformatf("vec%0d.stall", i), 32'(ex_stall), 32'(vec[i].xstall));
      if (vec[i].xreq) begin
        chk($sformatf("vec%0d.addr", i),  32'(mem_addr),  32'(vec[i].xaddr));
        chk($sformatf("vec%0d.wdata", i), 32'(mem_wdata), 32'(vec[i].xwd));
      end
    end

    // Asynchronous reset while a load is outstanding.
    drive(1'b1, 1'b1, 1'b0, 3'd3, 3'd3, 16'h0099, 16'h0, 1'b0, 16'h0);
    tick();
    chk("midrst.pre_req", 32'(mem_req), 32'(1'b1));
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0);
    #2 rst_ = 1'b0;
    #1;
    chk("midrst.req",   32'(mem_req),  32'(1'b0));
    chk("midrst.we_",   32'(we_),      32'(1'b1));
    chk("midrst.stall", 32'(ex_stall), 32'(1'b0));
    #2 rst_ = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst.noretire%0d", i), 32'({we_, mem_req}), 32'(2'b10));
    end
    mem_ack = 1'b0;

`ifdef MEMWB_BUSERR_EN
    // Load with no ack: abort after TIMEOUT wait cycles.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 3'd1, 3'd6, 16'h0050, 16'h0, 1'b0, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 16'hFFFF);
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      tick();
      chk($sformatf("tmo.wait%0d", i), 32'({mem_req, we_, bus_err}), 32'(3'b110));
    end
    tick();
    chk_retire("tmo.abort", 3'd1, 3'd6, 16'h0050, 16'h0000);
    chk("tmo.req",     32'(mem_req), 32'(1'b0));
    chk("tmo.bus_err", 32'(bus_err), 32'(1'b1));
    drive(1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 16'h0001, 16'h0, 1'b0, 16'h0);
    tick();
    tick();
    chk("tmo.sticky", 32'(bus_err), 32'(1'b1));
    do_reset();
    #1;
    chk("tmo.cleared", 32'(bus_err), 32'(1'b0));
    // Ack arriving on the expiry cycle wins.
    drive(1'b1, 1'b1, 1'b0, 3'd2, 3'd5, 16'h0060, 16'h0, 1'b0, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) tick();
    mem_ack = 1'b1;
    mem_rdata = 16'hC0DE;
    tick();
    chk_retire("tmo.ackwin", 3'd2, 3'd5, 16'h0060, 16'hC0DE);
    chk("tmo.ackwin.bus_err", 32'(bus_err), 32'(1'b0));
    mem_ack = 1'b0;
`else
    // Without the timeout, a long wait never retires and bus_err stays low.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 3'd1, 3'd6, 16'h0050, 16'h0, 1'b0, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("nowait%0d", i), 32'({mem_req, we_, bus_err}), 32'(3'b110));
    end
    mem_ack = 1'b1;
    mem_rdata = 16'h4321;
    tick();
    chk_retire("nowait.ack", 3'd1, 3'd6, 16'h0050, 16'h4321);
    mem_ack = 1'b0;
`endif

    // Random traffic against a queue-based model of the stage.
    begin
      pend_t pq[$];
      pend_t p;
      int waitc;
      logic [15:0] m_ve, m_vm, m_addr, m_wd;
      logic m_mwe, m_berr;
      logic e_we;
      logic [2:0] e_de, e_dm;
      logic v, ld, st, ack;
      logic [2:0] de, dm;
      logic [15:0] ve, va, rd;
      bit retire;
      do_reset();
      waitc = 0; m_ve = '0; m_vm = '0; m_addr = '0; m_wd = '0; m_mwe = 1'b0; m_berr = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        v = ($urandom_range(0, 3) != 0); ld = ($urandom_range(0, 2) == 0); st = ($urandom_range(0, 2) == 0);
        de = 3'($urandom); dm = 3'($urandom); ve = 16'($urandom); va = 16'($urandom);
        ack = ($urandom_range(0, 4) == 0); rd = 16'($urandom);
        drive(v, ld, st, de, dm, ve, va, ack, rd);
        chk("rnd.stall_pre", 32'(ex_stall), 32'(pq.size() != 0));
        e_we = 1'b1; e_de = '0; e_dm = '0; retire = 0;
        if (pq.size() == 0) begin
          if (v && (ld || st)) begin
            pq.push_back('{ld, de, dm, ve});
            waitc = 0; m_addr = ve; m_mwe = st && !ld; m_wd = ld ? 16'h0 : va;
          end else if (v) begin
            e_we = 1'b0; e_de = de; m_ve = ve; m_vm = '0;
          end
        end else if (ack) begin
          p = pq.pop_front(); retire = 1;
          m_vm = p.ld ? rd : 16'h0;
        end else begin
          waitc++;
`ifdef MEMWB_BUSERR_EN
          if (waitc == int'(TIMEOUT)) begin
            p = pq.pop_front(); retire = 1; m_vm = '0; m_berr = 1'b1;
          end
`endif
        end
        if (retire) begin
          e_we = 1'b0; e_de = p.de; e_dm = p.ld ? p.dm : 3'd0; m_ve = p.ve;
        end
        tick();
        chk("rnd.we_",  32'(we_),  32'(e_we));
        chk("rnd.dstE", 32'(dstE), 32'(e_de));
        chk("rnd.dstM", 32'(dstM), 32'(e_dm));
        chk("rnd.valE", 32'(valE), 32'(m_ve));
        chk("rnd.valM", 32'(valM), 32'(m_vm));
        chk("rnd.req",  32'(mem_req), 32'(pq.size() != 0));
        chk("rnd.mem_we", 32'(mem_we), 32'((pq.size() != 0) && m_mwe));
        chk("rnd.bus_err", 32'(bus_err), 32'(m_berr));
        if (pq.size() != 0) begin
          chk("rnd.addr",  32'(mem_addr),  32'(m_addr));
          chk("rnd.wdata", 32'(mem_wdata), 32'(m_wd));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
